// File: rtl/regfile_mp_sb.sv
// Parametrised register file: two registered read ports, two prioritised write ports, clear sweep, pending-write scoreboard.
// Latency: reads 1 cycle with write-first bypass; busy_a/busy_b combinational; clear sweep takes DEPTH cycles.
// Backpressure: none on ports; ready=0 during the sweep, when writes, reservations and init_req are ignored.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              init_req,
  output logic              ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  input  logic              wd_en,
  input  logic [ADDR_W-1:0] wd_addr,
  input  logic [DATA_W-1:0] wd_data,
  input  logic              ws_en,
  input  logic [ADDR_W-1:0] ws_addr,
  input  logic [DATA_W-1:0] ws_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              wr_conflict
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending, pending_nxt;
  logic              run, act, wd_ok, ws_ok, conflict;
  logic [DATA_W-1:0] rd_a, rd_b;

  // Register 0 is hardwired to zero only when ZERO_REG is set.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A cycle is "active" only in RUN without a sweep restart; everything else is dropped.
  assign run      = (state == ST_RUN);
  assign act      = run && !init_req;
  assign wd_ok    = act && wd_en && !is_zero(wd_addr);
  assign conflict = wd_ok && ws_en && (ws_addr == wd_addr);
  assign ws_ok    = act && ws_en && !is_zero(ws_addr) && !conflict;

  assign ready  = run;
  assign busy_a = run && pending[rs1_addr];
  assign busy_b = run && pending[rs2_addr];

  // Next state: sweep ends after writing the last register; init_req restarts it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:  if (init_req) state_nxt = ST_INIT;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Write-first read bypass; Rd data wins over Rs data on the same address.
  always_comb begin
    rd_a = mem[rs1_addr];
    rd_b = mem[rs2_addr];
    if (ws_ok && (ws_addr == rs1_addr)) rd_a = ws_data;
    if (ws_ok && (ws_addr == rs2_addr)) rd_b = ws_data;
    if (wd_ok && (wd_addr == rs1_addr)) rd_a = wd_data;
    if (wd_ok && (wd_addr == rs2_addr)) rd_b = wd_data;
    if (is_zero(rs1_addr)) rd_a = '0;
    if (is_zero(rs2_addr)) rd_b = '0;
  end

  // Scoreboard update: committed writes clear, a reservation in the same cycle sets again.
  always_comb begin
    pending_nxt = pending;
    if (!act) begin
      pending_nxt = '0;
    end else begin
      if (wd_ok) pending_nxt[wd_addr] = 1'b0;
      if (ws_ok) pending_nxt[ws_addr] = 1'b0;
      if (rsv_en && !is_zero(rsv_addr)) pending_nxt[rsv_addr] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Sweep counter: advances through INIT, rewinds on a restart request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               cnt <= '0;
    else if (state == ST_INIT)  cnt <= cnt + ADDR_W'(1);
    else if (init_req)          cnt <= '0;
  end

  // Storage array: zeroed by the sweep, written by the two ports otherwise.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else begin
      if (ws_ok) mem[ws_addr] <= ws_data;
      if (wd_ok) mem[wd_addr] <= wd_data;
    end
  end

  // Registered outputs and scoreboard state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_a       <= '0;
      bus_b       <= '0;
      pending     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      bus_a       <= act ? rd_a : '0;
      bus_b       <= act ? rd_b : '0;
      pending     <= pending_nxt;
      wr_conflict <= conflict;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (DATA_W=32, DEPTH=16, ZERO_REG=1).
// Vector table drives writes/reads/reservations; expected outputs go through a queue.
// Hand-written sequences cover the clear sweep, init_req and reset mid-sweep.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NV = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          init_req = 1'b0;
  logic          ready;
  logic [AW-1:0] rs1_addr = '0, rs2_addr = '0;
  logic [DW-1:0] bus_a, bus_b;
  logic          wd_en = 1'b0, ws_en = 1'b0, rsv_en = 1'b0;
  logic [AW-1:0] wd_addr = '0, ws_addr = '0, rsv_addr = '0;
  logic [DW-1:0] wd_data = '0, ws_data = '0;
  logic          busy_a, busy_b, wr_conflict;

  int checks = 0;
  int errors = 0;

  regfile_mp_sb #(.DATA_W(DW), .DEPTH(16), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clock(clock), .reset_n(reset_n), .init_req(init_req), .ready(ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .bus_a(bus_a), .bus_b(bus_b),
    .wd_en(wd_en), .wd_addr(wd_addr), .wd_data(wd_data),
    .ws_en(ws_en), .ws_addr(ws_addr), .ws_data(ws_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(busy_a), .busy_b(busy_b), .wr_conflict(wr_conflict)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          wd_en;
    logic [AW-1:0] wd_addr;
    logic [DW-1:0] wd_data;
    logic          ws_en;
    logic [AW-1:0] ws_addr;
    logic [DW-1:0] ws_data;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          exp_conf;
    logic          exp_busy_a;
    logic          exp_busy_b;
  } vec_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          conf;
    logic          ba;
    logic          bb;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wd_en = 1'b0; ws_en = 1'b0; rsv_en = 1'b0; init_req = 1'b0;
  endtask

  // Counts edges until ready rises; bounded so a stuck DUT still reaches the summary.
  task automatic count_init(output int n);
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   n;
    exp_t e;

    vecs[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd5, 32'h11111111, 1'b1, 4'd5, 32'h22222222, 1'b0, 4'd0, 4'd5, 4'd3, 32'h11111111, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd5, 32'h11111111, 32'h11111111, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd5, 32'h55555555, 1'b1, 4'd6, 32'h66666666, 1'b0, 4'd0, 4'd5, 4'd6, 32'h55555555, 32'h66666666, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd6, 4'd5, 32'h66666666, 32'h55555555, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd0, 32'h12345678, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 4'd0, 4'd3, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0, 4'd5, 32'h0, 32'h55555555, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd7, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 4'd7, 32'h00000077, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd5, 32'h00000077, 32'h55555555, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd7, 32'h00000078, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd7, 32'h00000078, 32'h00000078, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h00000079, 1'b0, 4'd0, 4'd7, 4'd3, 32'h00000079, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd7, 4'd9, 32'h00000079, 32'h0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 4'd9, 32'h00000099, 1'b1, 4'd9, 32'h000000AB, 1'b0, 4'd0, 4'd9, 4'd9, 32'h00000099, 32'h00000099, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 4'd2, 32'hA5A5A5A5, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 4'd5, 32'hA5A5A5A5, 32'h55555555, 1'b0, 1'b0, 1'b0};

    // Reset: create a real falling edge, then hold.
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    step(); step();
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_bus_a", bus_a, 32'h0);
    chk("rst_bus_b", bus_b, 32'h0);
    chk("rst_conflict", {31'b0, wr_conflict}, 32'h0);
    chk("rst_busy", {30'b0, busy_a, busy_b}, 32'h0);

    reset_n = 1'b1;
    count_init(n);
    chk("init_len", n, 16);

    // Every register reads zero after the sweep.
    for (int i = 0; i < 16; i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(15 - i);
      step();
      chk($sformatf("zero_a[%0d]", i), bus_a, 32'h0);
      chk($sformatf("zero_b[%0d]", 15 - i), bus_b, 32'h0);
    end

    // Table-driven vectors through the scoreboard queue.
    for (int v = 0; v < NV; v++) begin
      wd_en = vecs[v].wd_en; wd_addr = vecs[v].wd_addr; wd_data = vecs[v].wd_data;
      ws_en = vecs[v].ws_en; ws_addr = vecs[v].ws_addr; ws_data = vecs[v].ws_data;
      rsv_en = vecs[v].rsv_en; rsv_addr = vecs[v].rsv_addr;
      rs1_addr = vecs[v].rs1; rs2_addr = vecs[v].rs2;
      sb_q.push_back('{vecs[v].exp_a, vecs[v].exp_b, vecs[v].exp_conf, vecs[v].exp_busy_a, vecs[v].exp_busy_b});
      step();
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d_queue: got empty queue expected entry", v);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_bus_a", v), bus_a, e.a);
        chk($sformatf("v%0d_bus_b", v), bus_b, e.b);
        chk($sformatf("v%0d_conflict", v), {31'b0, wr_conflict}, {31'b0, e.conf});
        chk($sformatf("v%0d_busy_a", v), {31'b0, busy_a}, {31'b0, e.ba});
        chk($sformatf("v%0d_busy_b", v), {31'b0, busy_b}, {31'b0, e.bb});
      end
    end
    idle_inputs();

    // init_req in RUN: reservation and bus contents must be wiped.
    rsv_en = 1'b1; rsv_addr = 4'd10; rs1_addr = 4'd2;
    step();
    rsv_en = 1'b0; rs1_addr = 4'd10;
    #1;
    chk("pre_init_busy10", {31'b0, busy_a}, 32'h1);
    chk("pre_init_reg2", bus_a, 32'hA5A5A5A5);

    init_req = 1'b1; wd_en = 1'b1; wd_addr = 4'd4; wd_data = 32'h44444444;
    rsv_en = 1'b1; rsv_addr = 4'd11;
    step();
    init_req = 1'b0;
    chk("init_req_ready", {31'b0, ready}, 32'h0);
    chk("init_req_bus_a", bus_a, 32'h0);
    chk("init_req_busy", {31'b0, busy_a}, 32'h0);
    count_init(n);
    chk("init_req_len", n, 16);
    idle_inputs();
    rs1_addr = 4'd10; rs2_addr = 4'd11;
    #1;
    chk("post_init_busy10", {31'b0, busy_a}, 32'h0);
    chk("post_init_busy11", {31'b0, busy_b}, 32'h0);
    rs1_addr = 4'd2; rs2_addr = 4'd4;
    step();
    chk("post_init_reg2", bus_a, 32'h0);
    chk("post_init_reg4", bus_b, 32'h0);

    // Reset in the middle of a sweep restarts it from register 0.
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int k = 0; k < 5; k++) step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 32'h0);
    step();
    reset_n = 1'b1;
    count_init(n);
    chk("mid_rst_len", n, 16);

    // File is usable again after the restarted sweep.
    wd_en = 1'b1; wd_addr = 4'd12; wd_data = 32'hC0FFEE00; rs1_addr = 4'd12;
    step();
    idle_inputs();
    chk("final_bypass", bus_a, 32'hC0FFEE00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
